sd_dac_multi: RTL and testbench

//  Multi-channel, parametrised delta-sigma DAC with a buffered sample interface. Takes

---
 rtl/sd_dac_multi.sv | 138 +++++++++++++
 tb/tb_sd_dac_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac_multi.sv
// sd_dac_multi: multi-channel delta-sigma DAC with a one-deep staging buffer and tick-driven load.
// Define SD_DAC_ORDER2_EN to build second-order modulators; otherwise first-order only.
module sd_dac_multi #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int SIGNED_IN = 0,
    parameter int CLK_DIV   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*WIDTH-1:0] sample_i,
    input  logic                      sample_valid_i,
    output logic                      sample_ready_o,
    input  logic                      tick_i,
    input  logic                      mute_i,
    output logic                      underrun_o,
    output logic [CHANNELS-1:0]       dac_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] MID_U = {1'b1, {(WIDTH-1){1'b0}}};
    // Midscale expressed in the input encoding, so the active register holds raw samples
    localparam logic [WIDTH-1:0] MID_RAW = (SIGNED_IN != 0) ? {WIDTH{1'b0}} : MID_U;

    logic                      r_full;
    logic                      r_underrun;
    logic [CHANNELS*WIDTH-1:0] r_staged;
    logic [CHANNELS*WIDTH-1:0] r_active;
    logic [CNT_W-1:0]          r_ce_cnt;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_ce;

    function automatic logic [WIDTH-1:0] to_unsigned(input logic [WIDTH-1:0] s);
        if (SIGNED_IN != 0) begin
            return {~s[WIDTH-1], s[WIDTH-2:0]};
        end else begin
            return s;
        end
    endfunction

    assign w_accept       = sample_valid_i & ~r_full;
    assign w_load         = tick_i & r_full;
    assign w_ce           = (r_ce_cnt == {CNT_W{1'b0}});
    assign sample_ready_o = ~r_full;
    assign underrun_o     = r_underrun;

    // Clock-enable divider: ce fires when the count is zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ce_cnt <= {CNT_W{1'b0}};
        end else if (r_ce_cnt == CNT_LAST) begin
            r_ce_cnt <= {CNT_W{1'b0}};
        end else begin
            r_ce_cnt <= r_ce_cnt + CNT_W'(1);
        end
    end

    // Staging buffer, tick transfer and underrun flag; load and accept are mutually exclusive
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
            r_staged   <= {(CHANNELS*WIDTH){1'b0}};
            r_active   <= {CHANNELS{MID_RAW}};
        end else begin
            r_underrun <= tick_i & ~r_full;
            if (w_load) begin
                r_active <= r_staged;
                r_full   <= 1'b0;
            end else if (w_accept) begin
                r_staged <= sample_i;
                r_full   <= 1'b1;
            end
        end
    end

    genvar n;
    generate
        for (n = 0; n < CHANNELS; n++) begin : g_ch
            logic [WIDTH-1:0] w_u;
            logic             r_bit;

            assign w_u      = mute_i ? MID_U : to_unsigned(r_active[n*WIDTH +: WIDTH]);
            assign dac_o[n] = r_bit;

`ifdef SD_DAC_ORDER2_EN
            localparam logic [WIDTH+2:0] FB_I1   = {3'b001, {WIDTH{1'b0}}};
            localparam logic [WIDTH+4:0] FB_I2   = {5'b00001, {WIDTH{1'b0}}};
            localparam logic [WIDTH+4:0] HALF_I2 = {6'b000001, {(WIDTH-1){1'b0}}};

            logic [WIDTH+2:0] r_i1;
            logic [WIDTH+4:0] r_i2;
            logic [WIDTH+2:0] w_e;
            logic [WIDTH+4:0] w_d2;

            // Two's-complement integrators kept as plain vectors; wraparound matches signed math
            assign w_e  = {3'b000, w_u} - (r_bit ? FB_I1 : {(WIDTH+3){1'b0}});
            assign w_d2 = {{2{r_i1[WIDTH+2]}}, r_i1}
                        - (r_bit ? FB_I2 : {(WIDTH+5){1'b0}}) + HALF_I2;

            // Second-order loop: both integrators and the output bit advance on ce only
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_i1  <= {(WIDTH+3){1'b0}};
                    r_i2  <= {(WIDTH+5){1'b0}};
                    r_bit <= 1'b0;
                end else if (w_ce) begin
                    r_i1  <= r_i1 + w_e;
                    r_i2  <= r_i2 + w_d2;
                    r_bit <= ~r_i2[WIDTH+4];
                end
            end
`else
            localparam logic [WIDTH+1:0] SIGMA_RST = {2'b01, {WIDTH{1'b0}}};

            logic [WIDTH+1:0] r_sigma;
            logic [WIDTH+1:0] w_delta;

            // A set MSB adds 3<<WIDTH, which is -(1<<WIDTH) modulo the accumulator width
            assign w_delta = {2'b00, w_u}
                           + {r_sigma[WIDTH+1], r_sigma[WIDTH+1], {WIDTH{1'b0}}};

            // First-order loop: the output is the accumulator MSB from before the update
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_sigma <= SIGMA_RST;
                    r_bit   <= 1'b0;
                end else if (w_ce) begin
                    r_sigma <= r_sigma + w_delta;
                    r_bit   <= r_sigma[WIDTH+1];
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sd_dac_multi.sv
// tb_sd_dac_multi: directed sequence with random samples; three DUT configurations share one stimulus stream.
module tb_sd_dac_multi;
`ifdef SD_DAC_ORDER2_EN
    localparam int  TOL    = 8;
    localparam bit  EXACT0 = 1'b0;
`else
    localparam int  TOL    = 1;
    localparam bit  EXACT0 = 1'b1;
`endif
    localparam int  TOL_DIV = TOL + 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        tick;
    logic        mute;
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic        rdy0, rdy1, rdy2;
    logic        und0, und1, und2;
    logic [1:0]  dac0;
    logic [0:0]  dac1;
    logic [0:0]  dac2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: densities in the unsigned domain, 0..255
    int act0[2];
    int act1;
    int act2;
    int st0[2];
    int st1;
    int st2;
    bit st_full;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    sd_dac_multi #(.WIDTH(8), .CHANNELS(2), .SIGNED_IN(0), .CLK_DIV(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .sample_i(s0), .sample_valid_i(valid),
        .sample_ready_o(rdy0), .tick_i(tick), .mute_i(mute),
        .underrun_o(und0), .dac_o(dac0));

    sd_dac_multi #(.WIDTH(8), .CHANNELS(1), .SIGNED_IN(1), .CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .sample_i(s1), .sample_valid_i(valid),
        .sample_ready_o(rdy1), .tick_i(tick), .mute_i(mute),
        .underrun_o(und1), .dac_o(dac1));

    sd_dac_multi #(.WIDTH(8), .CHANNELS(1), .SIGNED_IN(0), .CLK_DIV(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .sample_i(s2), .sample_valid_i(valid),
        .sample_ready_o(rdy2), .tick_i(tick), .mute_i(mute),
        .underrun_o(und2), .dac_o(dac2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ones over 1024 cycles = 4 full modulator periods of 256 ce at CLK_DIV=1
    task automatic chk_dens(input string tag, input int obs, input int u, input int tol);
        int lo;
        int hi;
        lo = 4 * u - tol;
        if (lo < 0) lo = 0;
        hi = ((u == 0) && EXACT0) ? 0 : 4 * u + tol;
        n_vec++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b, input logic [7:0] c);
        s0 = {a1, a0};
        s1 = b;
        s2 = c;
        valid = 1'b1;
        @(negedge clk);
        chk("ready_before_load", rdy0, 32'(!st_full));
        step();
        valid = 1'b0;
        st0[0] = int'(a0);
        st0[1] = int'(a1);
        st1 = int'($signed(b)) + 128;
        st2 = int'(c);
        st_full = 1'b1;
        @(negedge clk);
        chk("ready_after_load", rdy0, 32'(!st_full));
        chk("ready_after_load_div", rdy2, 32'(!st_full));
        step();
    endtask

    task automatic do_tick();
        bit exp_und;
        exp_und = !st_full;
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (st_full) begin
            act0 = st0;
            act1 = st1;
            act2 = st2;
            st_full = 1'b0;
        end
        @(negedge clk);
        chk("underrun_pulse", und0, 32'(exp_und));
        chk("underrun_pulse_sgn", und1, 32'(exp_und));
        chk("ready_after_tick", rdy0, 32'(1));
        step();
        @(negedge clk);
        chk("underrun_one_cycle", und0, 32'(0));
        step();
    endtask

    task automatic measure(input string tag);
        int   c00;
        int   c01;
        int   c1;
        int   c2;
        int   bad;
        logic prev;
        c00 = 0; c01 = 0; c1 = 0; c2 = 0; bad = 0;
        repeat (12) step();
        @(negedge clk);
        prev = dac2[0];
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            c00 += int'(dac0[0]);
            c01 += int'(dac0[1]);
            c1  += int'(dac1[0]);
            c2  += int'(dac2[0]);
            if (dac2[0] !== prev) begin
                if (((cyc - 1) % 4) != 0) bad++;
                prev = dac2[0];
            end
        end
        chk_dens({tag, "_ch0"}, c00, mute ? 128 : act0[0], TOL);
        chk_dens({tag, "_ch1"}, c01, mute ? 128 : act0[1], TOL);
        chk_dens({tag, "_sgn"}, c1,  mute ? 128 : act1,    TOL);
        chk_dens({tag, "_div"}, c2,  mute ? 128 : act2,    TOL_DIV);
        chk({tag, "_ce_align"}, bad, 32'(0));
        step();
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rc;
        rst = 1'b1; valid = 1'b0; tick = 1'b0; mute = 1'b0;
        s0 = 16'h0000; s1 = 8'h00; s2 = 8'h00;
        act0[0] = 128; act0[1] = 128; act1 = 128; act2 = 128;
        st_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy0, 32'(1));
        chk("rst_ready_div", rdy2, 32'(1));
        chk("rst_underrun", und0, 32'(0));
        chk("rst_dac", dac0, 32'(0));
        chk("rst_dac_sgn", dac1, 32'(0));
        rst = 1'b0;
        measure("midscale_after_reset");

        // Fixed patterns: offset-binary 0x40/0xC0, signed -128, full-scale on the divided DUT
        load(8'h40, 8'hC0, 8'h80, 8'hFF);
        do_tick();
        measure("fixed_pattern");
        load(8'($urandom_range(255)), 8'($urandom_range(255)), 8'h7F, 8'($urandom_range(255)));
        do_tick();
        measure("signed_max");
        load(8'($urandom_range(255)), 8'($urandom_range(255)), 8'h00, 8'($urandom_range(255)));
        do_tick();
        measure("signed_zero");

        // Tick with nothing staged: underrun, density unchanged
        do_tick();
        measure("after_underrun");

        // Valid held while full must not overwrite the staged sample
        ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255)); rc = 8'($urandom_range(255));
        load(ra, rb, rc, ra);
        s0 = {rb ^ 8'h5A, ra ^ 8'h5A}; s1 = rc ^ 8'h5A; s2 = ra ^ 8'hA5;
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ready_low_while_full", rdy0, 32'(0));
            step();
        end
        valid = 1'b0;
        do_tick();
        measure("no_overwrite");

        // Accept and tick in the same cycle while empty
        ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255)); rc = 8'($urandom_range(255));
        s0 = {rb, ra}; s1 = rc; s2 = rb;
        valid = 1'b1; tick = 1'b1;
        step();
        valid = 1'b0; tick = 1'b0;
        st0[0] = int'(ra); st0[1] = int'(rb); st1 = int'($signed(rc)) + 128; st2 = int'(rb);
        st_full = 1'b1;
        @(negedge clk);
        chk("same_cycle_underrun", und0, 32'(1));
        chk("same_cycle_staged", rdy0, 32'(0));
        step();
        measure("same_cycle_hold");
        do_tick();
        measure("same_cycle_loaded");

        // Mute forces midscale while staging keeps working
        mute = 1'b1;
        measure("mute");
        load(8'($urandom_range(255)), 8'($urandom_range(255)),
             8'($urandom_range(255)), 8'($urandom_range(255)));
        do_tick();
        measure("mute_after_load");
        mute = 1'b0;
        measure("unmute");

        for (int r = 0; r < 2; r++) begin
            load(8'($urandom_range(255)), 8'($urandom_range(255)),
                 8'($urandom_range(255)), 8'($urandom_range(255)));
            do_tick();
            measure("random");
        end

        // Reset in the middle of a cycle with the staging buffer full
        load(8'hF0, 8'hF8, 8'h70, 8'hF0);
        do_tick();
        load(8'($urandom_range(255)), 8'($urandom_range(255)),
             8'($urandom_range(255)), 8'($urandom_range(255)));
        repeat (8) step();
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_dac", dac0, 32'(0));
        chk("midrst_dac_sgn", dac1, 32'(0));
        chk("midrst_ready", rdy0, 32'(1));
        chk("midrst_ready_div", rdy2, 32'(1));
        act0[0] = 128; act0[1] = 128; act1 = 128; act2 = 128;
        st_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        do_tick();
        measure("after_midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
